// File: rtl/amiga_eclk_bus.sv
// Amiga E-clock (6800-style) peripheral bus sequencer: grants VPA cycles aligned to the
// ten-phase E period. Optional eclk integrity checker selected by MINIMIG_ECLK_CHECK_EN.
module amiga_eclk_bus (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk7_en,
    input  logic [9:0] eclk,
    input  logic       req,
    output logic       vma,
    output logic       e_out,
    output logic       cia_stb,
    output logic       ack,
    output logic       sync_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ARM,
        VMA,
        EHI,
        DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_oneHot;
    logic [3:0] w_ph;
    logic       w_phEvt;
    logic       r_vma;
    logic       r_eOut;
    logic       r_ack;
    logic       r_ciaStb;

    assign w_oneHot = (eclk != 10'd0) && ((eclk & (eclk - 10'd1)) == 10'd0);
    assign w_phEvt  = clk7_en && w_oneHot;

    always_comb begin
        w_ph = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (eclk[k]) begin
                w_ph = 4'(k);
            end
        end
    end

    // A dropped req aborts only before VMA; once VMA is driven the cycle must finish.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_phEvt && req) begin
                    w_next = (w_ph <= 4'd3) ? ARM : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    w_next = IDLE;
                end else if (w_phEvt && w_ph == 4'd9) begin
                    w_next = ARM;
                end
            end
            ARM: begin
                if (!req) begin
                    w_next = IDLE;
                end else if (w_phEvt && w_ph == 4'd4) begin
                    w_next = VMA;
                end
            end
            VMA: begin
                if (w_phEvt && w_ph == 4'd5) begin
                    w_next = EHI;
                end
            end
            EHI: begin
                if (w_phEvt && w_ph == 4'd9) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (!req) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vma    <= 1'b0;
            r_eOut   <= 1'b0;
            r_ack    <= 1'b0;
            r_ciaStb <= 1'b0;
        end else begin
            r_vma    <= (w_next == VMA) || (w_next == EHI);
            r_eOut   <= (w_next == EHI);
            r_ack    <= (r_state == EHI) && (w_next == DONE);
            r_ciaStb <= (r_state == EHI) && (w_next == DONE);
        end
    end

    assign vma     = r_vma;
    assign e_out   = r_eOut;
    assign ack     = r_ack;
    assign cia_stb = r_ciaStb;

`ifdef MINIMIG_ECLK_CHECK_EN
    logic [3:0] r_prevPh;
    logic       r_havePrev;
    logic       r_syncErr;
    logic [3:0] w_prevPlus1;

    assign w_prevPlus1 = (r_prevPh == 4'd9) ? 4'd0 : r_prevPh + 4'd1;

    // Phase may repeat or advance by one; anything else means the E divider slipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prevPh   <= 4'd0;
            r_havePrev <= 1'b0;
            r_syncErr  <= 1'b0;
        end else if (clk7_en) begin
            if (!w_oneHot) begin
                r_syncErr <= 1'b1;
            end else begin
                if (r_havePrev && (w_ph != r_prevPh) && (w_ph != w_prevPlus1)) begin
                    r_syncErr <= 1'b1;
                end
                r_prevPh   <= w_ph;
                r_havePrev <= 1'b1;
            end
        end
    end

    assign sync_err = r_syncErr;
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_amiga_eclk_bus.sv
// Scoreboard bench for amiga_eclk_bus: stimulus pushes expected vma/e_out/ack cycles,
// a monitor process pops and compares as the DUT presents them.
module tb_amiga_eclk_bus;

`ifdef MINIMIG_ECLK_CHECK_EN
    localparam int SyncExp = 1;
`else
    localparam int SyncExp = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk7_en = 1'b0;
    logic [9:0] eclk = 10'd1;
    logic       req = 1'b0;
    logic       vma;
    logic       e_out;
    logic       cia_stb;
    logic       ack;
    logic       sync_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int vmaQ[$];
    int eQ[$];
    int ackQ[$];

    amiga_eclk_bus dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk7_en  (clk7_en),
        .eclk     (eclk),
        .req      (req),
        .vma      (vma),
        .e_out    (e_out),
        .cia_stb  (cia_stb),
        .ack      (ack),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Phase events on every 4th cycle, E phase advancing once per event.
    initial begin
        forever begin
            @(negedge clk);
            clk7_en = (cyc % 4 == 0);
            if (cyc % 4 == 0) eclk = 10'd1 << ((cyc / 4) % 10);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: cycle=%0d required=finish", cyc);
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic gotoCycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic applyStimulus(input int atCycle, input logic reqVal);
        gotoCycle(atCycle);
        req = reqVal;
    endtask

    function automatic int nextEvent(input int ph, input int minCyc);
        int n = minCyc;
        while (n % 40 != ph * 4) n++;
        return n;
    endfunction

    task automatic expectCycle(input int t, input int vOff, input int eOff, input int aOff);
        vmaQ.push_back(t + vOff);
        eQ.push_back(t + eOff);
        ackQ.push_back(t + aOff);
    endtask

    // Monitor: rising edges of vma/e_out and every ack pulse are matched against the queues.
    initial begin
        logic prevVma = 1'b0;
        logic prevE = 1'b0;
        int vmaRise = 0;
        int eRise = 0;
        forever begin
            @(negedge clk);
            if (vma && !prevVma) begin
                if (vmaQ.size() == 0) checkOutput("vma_unexpected", cyc, -1);
                else checkOutput("vma_rise", cyc, vmaQ.pop_front());
                vmaRise = cyc;
            end
            if (!vma && prevVma && rst_n) checkOutput("vma_width", cyc - vmaRise, 20);
            if (e_out && !prevE) begin
                if (eQ.size() == 0) checkOutput("e_unexpected", cyc, -1);
                else checkOutput("e_rise", cyc, eQ.pop_front());
                eRise = cyc;
            end
            if (!e_out && prevE && rst_n) checkOutput("e_width", cyc - eRise, 16);
            if (ack || cia_stb) begin
                checkOutput("stb_eq_ack", int'(cia_stb), int'(ack));
                if (ack) begin
                    if (ackQ.size() == 0) checkOutput("ack_unexpected", cyc, -1);
                    else checkOutput("ack_cycle", cyc, ackQ.pop_front());
                    checkOutput("ack_at_vma_fall", int'({prevVma, vma, e_out}), 4);
                end
            end
            prevVma = vma;
            prevE = e_out;
        end
    end

    initial begin
        int t;
        int p;
        repeat (3) @(negedge clk);
        checkOutput("rst_vma", int'(vma), 0);
        checkOutput("rst_e_out", int'(e_out), 0);
        checkOutput("rst_ack", int'(ack), 0);
        checkOutput("rst_cia_stb", int'(cia_stb), 0);
        checkOutput("rst_sync_err", int'(sync_err), 0);
        rst_n = 1'b1;

        // Basic cycle from ph0, then req held high: no second cycle until req drops.
        t = nextEvent(0, cyc + 1);
        expectCycle(t, 17, 21, 37);
        applyStimulus(t, 1'b1);
        gotoCycle(t + 57);
        checkOutput("hold_no_cycle", int'(vma), 0);
        p = nextEvent(2, cyc + 3);
        expectCycle(p, 9, 13, 29);
        applyStimulus(p - 2, 1'b0);
        applyStimulus(p - 1, 1'b1);
        applyStimulus(p + 30, 1'b0);

        // First sampled at ph5: waits a full E period before VMA.
        t = nextEvent(5, cyc + 4);
        expectCycle(t, 37, 41, 57);
        applyStimulus(t, 1'b1);
        gotoCycle(t + 36);
        checkOutput("wait_no_vma", int'(vma), 0);
        applyStimulus(t + 58, 1'b0);

        // Abort in ARM.
        t = nextEvent(0, cyc + 4);
        applyStimulus(t, 1'b1);
        applyStimulus(t + 8, 1'b0);
        gotoCycle(t + 20);
        checkOutput("abort_vma", int'(vma), 0);
        gotoCycle(t + 25);
        checkOutput("abort_e_out", int'(e_out), 0);

        // req dropped during EHI: cycle still completes.
        t = nextEvent(0, cyc + 4);
        expectCycle(t, 17, 21, 37);
        applyStimulus(t, 1'b1);
        applyStimulus(t + 25, 1'b0);
        gotoCycle(t + 45);

        // Corrupted eclk at the ARM ph4 event: no transition, next E period used instead.
        t = nextEvent(0, cyc + 4);
        expectCycle(t, 57, 61, 77);
        applyStimulus(t, 1'b1);
        gotoCycle(t + 16);
        #1 eclk = 10'b0000000011;
        gotoCycle(t + 18);
        checkOutput("glitch_no_vma", int'(vma), 0);
        checkOutput("glitch_sync_err", int'(sync_err), SyncExp);
        applyStimulus(t + 78, 1'b0);
        gotoCycle(t + 82);
        checkOutput("sync_err_sticky", int'(sync_err), SyncExp);

        // Asynchronous reset in the middle of VMA.
        t = nextEvent(0, cyc + 4);
        vmaQ.push_back(t + 17);
        applyStimulus(t, 1'b1);
        gotoCycle(t + 18);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_vma", int'(vma), 0);
        checkOutput("async_e_out", int'(e_out), 0);
        checkOutput("async_ack", int'(ack), 0);
        checkOutput("async_cia_stb", int'(cia_stb), 0);
        checkOutput("async_sync_err", int'(sync_err), 0);
        req = 1'b0;
        gotoCycle(t + 22);
        rst_n = 1'b1;

        // Fresh evaluation after reset.
        t = nextEvent(0, cyc + 4);
        expectCycle(t, 17, 21, 37);
        applyStimulus(t, 1'b1);
        applyStimulus(t + 40, 1'b0);
        gotoCycle(t + 50);
        checkOutput("post_reset_sync_err", int'(sync_err), 0);

        checkOutput("vmaQ_drained", vmaQ.size(), 0);
        checkOutput("eQ_drained", eQ.size(), 0);
        checkOutput("ackQ_drained", ackQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/amiga_eclk_bus.md
AMIGA_ECLK_BUS -- requirements
Module: amiga_eclk_bus

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: 28 MHz system clock (clk_28 domain); the only clock.
REQ-002 The module SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have the port clk7_en, input, 1 bit: one-cycle 7 MHz enable, active 1 of every 4 clk cycles.
REQ-004 The module SHALL have the port eclk, input, 10 bits: one-hot E-phase enables; bit k set means E-phase k, range 0..9.
REQ-005 The module SHALL have the port req, input, 1 bit: level request for a 6800-style peripheral cycle (VPA-decoded CPU access).
REQ-006 The module SHALL have the port vma, output, 1 bit: valid memory address to peripherals.
REQ-007 The module SHALL have the port e_out, output, 1 bit: E clock high window for the granted cycle.
REQ-008 The module SHALL have the port cia_stb, output, 1 bit: one-cycle peripheral latch strobe at E falling edge.
REQ-009 The module SHALL have the port ack, output, 1 bit: one-cycle completion pulse to the CPU bus (DTACK equivalent).
REQ-010 The module SHALL have the port sync_err, output, 1 bit: sticky eclk integrity error (see Configuration).

Function
REQ-011 A phase event SHALL be defined as a clk cycle with clk7_en=1; its phase ph is the index of the set bit of eclk.
REQ-012 The state machine SHALL have the states IDLE, WAIT, ARM, VMA, EHI and DONE; state changes occur only as listed in REQ-013 to REQ-018.
REQ-013 IDLE: on a phase event with req=1, the machine SHALL go to ARM if ph is 0..3, or to WAIT if ph is 4..9.
REQ-014 WAIT: on a phase event with ph=9, the machine SHALL go to ARM. If req=0 in any cycle, it SHALL go to IDLE.
REQ-015 ARM: on a phase event with ph=4, the machine SHALL go to VMA. If req=0 in any cycle, it SHALL go to IDLE (abort, no outputs).
REQ-016 VMA: on a phase event with ph=5, the machine SHALL go to EHI. req SHALL be ignored; the cycle always completes.
REQ-017 EHI: on a phase event with ph=9, the machine SHALL go to DONE. req SHALL be ignored.
REQ-018 DONE: the machine SHALL stay in DONE while req=1, and go to IDLE in the cycle after req=0. A new cycle SHALL require req to be deasserted first.
REQ-019 All outputs SHALL be registered. vma=1 exactly while in VMA or EHI; e_out=1 exactly while in EHI.
REQ-020 cia_stb and ack SHALL both be 1 for exactly the single cycle after the EHI->DONE transition, and 0 otherwise.
REQ-021 Timing: vma high for 20 clk cycles, e_out high for 16 cycles; ack/cia_stb coincide with the falling edge of vma and e_out.
REQ-022 Latency: req sampled at a ph=0 event at cycle T SHALL give vma=1 at T+17, e_out=1 at T+21, and ack=1 at T+37.
REQ-023 A phase event with eclk not one-hot SHALL cause no state transition.

Reset
REQ-024 With rst_n=0, the state SHALL be IDLE immediately, and vma, e_out, cia_stb, ack and sync_err SHALL be 0, including mid-cycle.
REQ-025 After rst_n rises, the first phase event SHALL be treated as a fresh IDLE evaluation.

Configuration
REQ-026 The macro MINIMIG_ECLK_CHECK_EN SHALL select the eclk integrity checker.
REQ-027 With MINIMIG_ECLK_CHECK_EN defined, sync_err SHALL be set on a phase event with eclk not one-hot. It SHALL also be set on a phase event whose ph is not (previous ph + 1) mod 10 and not equal to the previous ph; the first event after reset is exempt. Once set, sync_err SHALL stay 1 until reset.
REQ-028 Without MINIMIG_ECLK_CHECK_EN, sync_err SHALL be constant 0, and no checker logic SHALL be present.

Verification
REQ-029 Scenario: req=1 before a ph=0 event at T -> vma 1 during T+17..T+36, e_out 1 during T+21..T+36, ack and cia_stb pulse at T+37.
REQ-030 Scenario: req rises so that it is first sampled at a ph=5 event -> machine in WAIT; vma is asserted only after the next E period's ph=4 event.
REQ-031 Scenario: req drops while in ARM -> IDLE next cycle; vma, e_out and ack never asserted.
REQ-032 Scenario: req drops while in EHI -> cycle completes; ack pulses at the ph=9 event +1.
REQ-033 Scenario: req held high after ack -> no second cycle; req low for 1 cycle then high -> new cycle at the next eligible phase.
REQ-034 Scenario: rst_n pulsed low during VMA -> all outputs 0 asynchronously. With MINIMIG_ECLK_CHECK_EN, eclk=10'b0000000011 at a phase event -> sync_err=1 and stays 1.
